// File: rtl/writeback_commit_unit.sv
// writeback_commit_unit
//   Commits MEM/WB results to the scalar and vector register files.
//   Scalar results are selected and written one registered cycle after
//   acceptance. Vector results are latched and serialized over a narrow
//   vector RF write port as NB = VEC_W/VEC_PORT_W beats. While a burst is
//   in progress wb_busy stalls the upstream pipeline; it drops during the
//   last beat so the next instruction is accepted with no bubble.
//
// Optional feature: define WB_BYPASS_EN to add the byp_valid/byp_rd/byp_data
//   outputs, which expose the accepted scalar request combinationally so
//   decode can forward it one cycle early.
//
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   wre_wb/vwre_wb scalar / vector write requests
//   sel_s, sel_v   scalar / vector source selects
//   mem_data, vmem_data, calc_data, calc_vector  candidate results
//   rd_wb          destination register
//   sreg_*         scalar RF write port
//   vreg_*         vector RF beat write port (beat k = bits [k*VEC_PORT_W +: VEC_PORT_W])
//   wb_busy        stall to MEM/WB and earlier stages
module writeback_commit_unit #(
  parameter int SCALAR_W   = 16,
  parameter int VEC_W      = 128,
  parameter int VEC_PORT_W = 32,
  parameter int REG_AW     = 5,
  localparam int NB        = VEC_W / VEC_PORT_W,
  localparam int BW        = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wre_wb,
  input  logic                  vwre_wb,
  input  logic [1:0]            sel_s,
  input  logic [1:0]            sel_v,
  input  logic [SCALAR_W-1:0]   mem_data,
  input  logic [VEC_W-1:0]      vmem_data,
  input  logic [SCALAR_W-1:0]   calc_data,
  input  logic [VEC_W-1:0]      calc_vector,
  input  logic [REG_AW-1:0]     rd_wb,
  output logic                  sreg_we,
  output logic [REG_AW-1:0]     sreg_waddr,
  output logic [SCALAR_W-1:0]   sreg_wdata,
  output logic                  vreg_we,
  output logic [REG_AW-1:0]     vreg_waddr,
  output logic [BW-1:0]         vreg_beat,
  output logic [VEC_PORT_W-1:0] vreg_wdata,
  output logic                  wb_busy
`ifdef WB_BYPASS_EN
  ,
  output logic                  byp_valid,
  output logic [REG_AW-1:0]     byp_rd,
  output logic [SCALAR_W-1:0]   byp_data
`endif
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  function automatic logic [SCALAR_W-1:0] scalar_sel(input logic [1:0] sel,
                                                     input logic [SCALAR_W-1:0] calc,
                                                     input logic [SCALAR_W-1:0] mem);
    case (sel)
      2'b00:   return calc;
      2'b01:   return mem;
      2'b10:   return SCALAR_W'({mem[7:0], 8'h00});
      default: return '0;
    endcase
  endfunction

  function automatic logic [VEC_W-1:0] vector_sel(input logic [1:0] sel,
                                                  input logic [VEC_W-1:0] cvec,
                                                  input logic [VEC_W-1:0] vmem,
                                                  input logic [SCALAR_W-1:0] calc);
    case (sel)
      2'b00:   return cvec;
      2'b01:   return vmem;
      2'b10:   return {(VEC_W / SCALAR_W){calc}};
      default: return '0;
    endcase
  endfunction

  state_t                state, state_nxt;
  logic [BW-1:0]         beat;
  logic                  beat_last;
  logic                  accept;
  logic                  swr_p0;
  logic                  vload_p0;
  logic [SCALAR_W-1:0]   smux_p0;
  logic                  vld_p1;
  logic [REG_AW-1:0]     srd_p1;
  logic [SCALAR_W-1:0]   sdat_p1;
  logic [VEC_W-1:0]      vec_p1;
  logic [REG_AW-1:0]     vrd_p1;

  // Stage p0: acceptance and source selection on the incoming MEM/WB values
  assign beat_last = (beat == BW'(NB - 1));
  assign accept    = ~wb_busy;
  assign swr_p0    = accept & wre_wb & (rd_wb != '0);
  assign vload_p0  = accept & vwre_wb;
  assign smux_p0   = scalar_sel(sel_s, calc_data, mem_data);

`ifdef WB_BYPASS_EN
  assign byp_valid = swr_p0;
  assign byp_rd    = rd_wb;
  assign byp_data  = smux_p0;
`endif

  // Stage p1: scalar write register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      srd_p1  <= '0;
      sdat_p1 <= '0;
    end else begin
      vld_p1 <= swr_p0;
      if (swr_p0) begin
        srd_p1  <= rd_wb;
        sdat_p1 <= smux_p0;
      end
    end
  end

  assign sreg_we    = vld_p1;
  assign sreg_waddr = srd_p1;
  assign sreg_wdata = sdat_p1;

  // Stage p1: vector latch, beat counter and burst state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      beat   <= '0;
      vec_p1 <= '0;
      vrd_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (vload_p0) begin
        vec_p1 <= vector_sel(sel_v, calc_vector, vmem_data, calc_data);
        vrd_p1 <= rd_wb;
        beat   <= '0;
      end else if (state == BURST) begin
        beat <= beat_last ? '0 : beat + 1'b1;
      end
    end
  end

  // A new vector can only be loaded in IDLE or during the last beat, which
  // is exactly when accept is high, so vload_p0 alone decides re-entry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vload_p0) state_nxt = BURST;
      BURST:   if (beat_last) state_nxt = vload_p0 ? BURST : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vreg_we    = 1'b0;
    vreg_waddr = '0;
    vreg_beat  = '0;
    vreg_wdata = '0;
    wb_busy    = 1'b0;
    if (state == BURST) begin
      vreg_we    = 1'b1;
      vreg_waddr = vrd_p1;
      vreg_beat  = beat;
      vreg_wdata = vec_p1[beat * VEC_PORT_W +: VEC_PORT_W];
      wb_busy    = ~beat_last;
    end
  end

endmodule

// File: tb/tb_writeback_commit_unit.sv
module tb_writeback_commit_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         wre_wb, vwre_wb;
  logic [1:0]   sel_s, sel_v;
  logic [15:0]  mem_data, calc_data;
  logic [127:0] vmem_data, calc_vector;
  logic [4:0]   rd_wb;
  logic         sreg_we;
  logic [4:0]   sreg_waddr;
  logic [15:0]  sreg_wdata;
  logic         vreg_we;
  logic [4:0]   vreg_waddr;
  logic [1:0]   vreg_beat;
  logic [31:0]  vreg_wdata;
  logic         wb_busy;
`ifdef WB_BYPASS_EN
  logic         byp_valid;
  logic [4:0]   byp_rd;
  logic [15:0]  byp_data;
`endif

  int tests = 0;
  int fails = 0;

  writeback_commit_unit dut (
    .clk(clk), .reset(reset), .wre_wb(wre_wb), .vwre_wb(vwre_wb),
    .sel_s(sel_s), .sel_v(sel_v), .mem_data(mem_data), .vmem_data(vmem_data),
    .calc_data(calc_data), .calc_vector(calc_vector), .rd_wb(rd_wb),
    .sreg_we(sreg_we), .sreg_waddr(sreg_waddr), .sreg_wdata(sreg_wdata),
    .vreg_we(vreg_we), .vreg_waddr(vreg_waddr), .vreg_beat(vreg_beat),
    .vreg_wdata(vreg_wdata), .wb_busy(wb_busy)
`ifdef WB_BYPASS_EN
    , .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] vld, va, vb, vbc;
    int busy_cnt;
    vld = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    va  = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    vb  = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    vbc = {4{32'h00A500A5}};

    reset = 1'b1; wre_wb = 0; vwre_wb = 0; sel_s = 0; sel_v = 0;
    mem_data = 0; calc_data = 0; vmem_data = 0; calc_vector = 0; rd_wb = 0;
    #2;
    chk("rst_sreg_we", sreg_we, 0);
    chk("rst_sreg_waddr", sreg_waddr, 0);
    chk("rst_sreg_wdata", sreg_wdata, 0);
    chk("rst_vreg_we", vreg_we, 0);
    chk("rst_vreg_wdata", vreg_wdata, 0);
    chk("rst_vreg_beat", vreg_beat, 0);
    chk("rst_busy", wb_busy, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Idle inputs: nothing happens for 10 cycles
    for (int i = 0; i < 10; i++) begin
      chk("idle_busy", wb_busy, 0);
      chk("idle_sreg_we", sreg_we, 0);
      chk("idle_vreg_we", vreg_we, 0);
      step();
    end

    // Scalar write from calc_data
    wre_wb = 1; rd_wb = 3; sel_s = 2'b00; calc_data = 16'hBEEF;
    step();
    wre_wb = 0;
    chk("s_we", sreg_we, 1);
    chk("s_waddr", sreg_waddr, 3);
    chk("s_wdata", sreg_wdata, 16'hBEEF);
    step();
    chk("s_we_one_cycle", sreg_we, 0);

    // r0 is never written
    wre_wb = 1; rd_wb = 0;
    step();
    wre_wb = 0;
    chk("s_r0_we", sreg_we, 0);

    // Other scalar sources
    wre_wb = 1; rd_wb = 4; sel_s = 2'b01; mem_data = 16'h12AB;
    step();
    chk("s_mem_wdata", sreg_wdata, 16'h12AB);
    chk("s_mem_waddr", sreg_waddr, 4);
    rd_wb = 5; sel_s = 2'b10;
    step();
    chk("s_shift_wdata", sreg_wdata, 16'hAB00);
    chk("s_shift_we", sreg_we, 1);
    rd_wb = 6; sel_s = 2'b11;
    step();
    wre_wb = 0;
    chk("s_zero_wdata", sreg_wdata, 0);
    chk("s_zero_waddr", sreg_waddr, 6);
    step();

    // Vector write from vmem_data: four beats, three stall cycles
    vwre_wb = 1; rd_wb = 7; sel_v = 2'b01; vmem_data = vld;
    step();
    vwre_wb = 0;
    busy_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      chk("v_we", vreg_we, 1);
      chk("v_waddr", vreg_waddr, 7);
      chk("v_beat", vreg_beat, k);
      chk("v_wdata", vreg_wdata, vld[k*32 +: 32]);
      chk("v_busy", wb_busy, (k != 3));
      if (wb_busy) busy_cnt++;
      step();
    end
    chk("v_busy_count", busy_cnt, 3);
    chk("v_end_we", vreg_we, 0);
    chk("v_end_busy", wb_busy, 0);

    // Back-to-back vectors; second one held by the stall, with a scalar write
    vwre_wb = 1; rd_wb = 1; sel_v = 2'b00; calc_vector = va;
    step();
    rd_wb = 2; calc_vector = vb; wre_wb = 1; sel_s = 2'b00; calc_data = 16'h1111;
    for (int i = 0; i < 8; i++) begin
      chk("bb_we", vreg_we, 1);
      chk("bb_waddr", vreg_waddr, (i < 4) ? 1 : 2);
      chk("bb_beat", vreg_beat, i % 4);
      chk("bb_wdata", vreg_wdata, (i < 4) ? va[(i%4)*32 +: 32] : vb[(i%4)*32 +: 32]);
      chk("bb_sreg_we", sreg_we, (i == 4));
      if (i == 4) begin
        chk("bb_sreg_waddr", sreg_waddr, 2);
        chk("bb_sreg_wdata", sreg_wdata, 16'h1111);
        vwre_wb = 0; wre_wb = 0;
      end
      step();
    end
    chk("bb_end_we", vreg_we, 0);

    // Broadcast of calc_data into every 16-bit lane
    vwre_wb = 1; rd_wb = 9; sel_v = 2'b10; calc_data = 16'h00A5;
    step();
    vwre_wb = 0;
    for (int k = 0; k < 4; k++) begin
      chk("bc_wdata", vreg_wdata, vbc[k*32 +: 32]);
      chk("bc_beat", vreg_beat, k);
      step();
    end

    // Reset during beat 1 drops the rest of the burst
    vwre_wb = 1; rd_wb = 5; sel_v = 2'b01; vmem_data = vld;
    step();
    vwre_wb = 0;
    step();
    chk("rb_beat1", vreg_beat, 1);
    reset = 1'b1;
    #1;
    chk("rb_we", vreg_we, 0);
    chk("rb_busy", wb_busy, 0);
    chk("rb_wdata", vreg_wdata, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rb_no_beats", vreg_we, 0);
      step();
    end
    wre_wb = 1; rd_wb = 6; sel_s = 2'b00; calc_data = 16'h5A5A;
    step();
    wre_wb = 0;
    chk("rb_s_we", sreg_we, 1);
    chk("rb_s_waddr", sreg_waddr, 6);
    chk("rb_s_wdata", sreg_wdata, 16'h5A5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
